// File: rtl/mf8_ram_arb.sv
// Shares one single-port byte RAM between the mf8 core data port (priority) and a host port.
// Core: mem_cs 2 cycles after strobe, c_ready low while pending; host: mem_cs 1 cycle after h_req, h_ack pulse.
module mf8_ram_arb #(
    parameter int AW       = 10,
    parameter int RAM_LAT  = 1,
    parameter int HOST_MAX = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          c_rd,
    input  logic          c_wr,
    input  logic [15:0]   c_addr,
    input  logic [7:0]    c_wdata,
    output logic [7:0]    c_rdata,
    output logic          c_ready,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [7:0]    h_wdata,
    output logic [7:0]    h_rdata,
    output logic          h_ack,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          arb_err
);

    typedef enum logic [1:0] {S_IDLE, S_C_ACC, S_H_ACC, S_WAIT} state_t;

    state_t          r_state, w_next;
    logic            r_own_host;
    logic [1:0]      r_lat_cnt;
    logic            r_c_pend, r_c_we;
    logic [AW-1:0]   r_c_addr;
    logic [7:0]      r_c_wdata, r_c_rdata, r_h_rdata;
    logic            r_h_ack, r_err;
    logic            r_mem_cs, r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [7:0]      r_mem_wdata;
    logic [7:0]      r_hcnt;

    logic w_c_any, w_c_both, w_c_strobe, w_viol;
    logic w_host_ok, w_force, w_lat_done, w_c_done, w_h_done;
    logic w_grant_h, w_host_busy, w_unused_hi;

    assign w_unused_hi = ^c_addr[15:AW];

    // A strobe is accepted only while no core access is outstanding.
    assign w_c_any     = c_rd | c_wr;
    assign w_c_both    = c_rd & c_wr;
    assign w_c_strobe  = w_c_any & ~w_c_both & ~r_c_pend;
    assign w_viol      = w_c_both | (w_c_any & r_c_pend);
    assign w_host_ok   = h_req & ~r_h_ack;
    assign w_force     = w_host_ok & (r_hcnt == 8'(HOST_MAX));
    assign w_lat_done  = (r_lat_cnt == 2'(RAM_LAT - 1));
    assign w_grant_h   = (r_state == S_IDLE) && (w_next == S_H_ACC);
    assign w_host_busy = (r_state == S_H_ACC) || ((r_state == S_WAIT) && r_own_host) || r_h_ack;

    always_comb begin
        w_next   = r_state;
        w_c_done = 1'b0;
        w_h_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A fresh core strobe holds off the host so the core keeps priority.
                if (w_force)                       w_next = S_H_ACC;
                else if (r_c_pend)                 w_next = S_C_ACC;
                else if (!w_c_strobe && w_host_ok) w_next = S_H_ACC;
            end
            S_C_ACC: begin
                if (r_mem_we) begin
                    w_next   = S_IDLE;
                    w_c_done = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_H_ACC: begin
                if (r_mem_we) begin
                    w_next   = S_IDLE;
                    w_h_done = 1'b1;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_lat_done) begin
                    w_next   = S_IDLE;
                    w_h_done = r_own_host;
                    w_c_done = ~r_own_host;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_own_host  <= 1'b0;
            r_lat_cnt   <= 2'd0;
            r_c_pend    <= 1'b0;
            r_c_we      <= 1'b0;
            r_c_addr    <= '0;
            r_c_wdata   <= 8'd0;
            r_c_rdata   <= 8'd0;
            r_h_rdata   <= 8'd0;
            r_h_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_hcnt      <= 8'd0;
        end else begin
            r_state <= w_next;
            r_h_ack <= w_h_done;
            r_err   <= r_err | w_viol;

            if (w_next == S_C_ACC) begin
                r_mem_cs    <= 1'b1;
                r_mem_we    <= r_c_we;
                r_mem_addr  <= r_c_addr;
                r_mem_wdata <= r_c_wdata;
                r_own_host  <= 1'b0;
            end else if (w_next == S_H_ACC) begin
                r_mem_cs    <= 1'b1;
                r_mem_we    <= h_we;
                r_mem_addr  <= h_addr;
                r_mem_wdata <= h_wdata;
                r_own_host  <= 1'b1;
            end else begin
                r_mem_cs <= 1'b0;
                r_mem_we <= 1'b0;
            end

            r_lat_cnt <= (r_state == S_WAIT) ? r_lat_cnt + 2'd1 : 2'd0;
            if ((r_state == S_WAIT) && w_lat_done) begin
                if (r_own_host) r_h_rdata <= mem_rdata;
                else            r_c_rdata <= mem_rdata;
            end

            if (w_c_done) begin
                r_c_pend <= 1'b0;
            end else if (w_c_strobe) begin
                r_c_pend  <= 1'b1;
                r_c_we    <= c_wr;
                r_c_addr  <= c_addr[AW-1:0];
                r_c_wdata <= c_wdata;
            end

            if (!h_req || w_grant_h || w_host_busy) r_hcnt <= 8'd0;
            else if (r_hcnt != 8'(HOST_MAX))        r_hcnt <= r_hcnt + 8'd1;
        end
    end

    assign c_rdata   = r_c_rdata;
    assign c_ready   = ~r_c_pend;
    assign h_rdata   = r_h_rdata;
    assign h_ack     = r_h_ack;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign arb_err   = r_err;

endmodule

// File: tb/tb_mf8_ram_arb.sv
// Scoreboard bench for mf8_ram_arb: expected RAM accesses and completions are queued with their cycle.
module tb_mf8_ram_arb;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int HM  = 4;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          c_rd, c_wr, h_req, h_we;
    logic [15:0]   c_addr;
    logic [7:0]    c_wdata, h_wdata, c_rdata, h_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] h_addr, mem_addr;
    logic          c_ready, h_ack, mem_cs, mem_we, arb_err;

    mf8_ram_arb #(.AW(AW), .RAM_LAT(LAT), .HOST_MAX(HM)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_ack(h_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // RAM model: read data appears LAT cycles after mem_cs, poisoned otherwise.
    logic [7:0] tb_ram [1024];
    logic [7:0] pipe [LAT];
    always @(posedge Clk) begin
        if (mem_cs && mem_we) tb_ram[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_cs && !mem_we) ? tb_ram[mem_addr] : 8'hEE;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct { int cyc; bit we; int addr; int dat; } mem_e_t;
    typedef struct { int cyc; int dat; } cpl_e_t;
    mem_e_t mem_q[$];
    cpl_e_t c_q[$];
    cpl_e_t h_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int exp_c = 0;
    int exp_h = 0;
    int T;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) step();
    endtask

    task automatic push_mem(input int c, input bit we, input int a, input int d);
        mem_e_t e;
        e.cyc = c; e.we = we; e.addr = a; e.dat = d;
        mem_q.push_back(e);
    endtask

    task automatic push_c(input int c, input int d);
        cpl_e_t e;
        e.cyc = c; e.dat = d;
        c_q.push_back(e);
    endtask

    task automatic push_h(input int c, input int d);
        cpl_e_t e;
        e.cyc = c; e.dat = d;
        h_q.push_back(e);
    endtask

    task automatic core_strobe(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        c_rd = rd; c_wr = wr; c_addr = a; c_wdata = d;
        step();
        c_rd = 1'b0; c_wr = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
        for (int i = 0; i < 40; i++) begin
            step();
            if (h_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("host_ack_timeout", 0, 1);
        step();
        h_req = 1'b0; h_we = 1'b0;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_c_ready"}, c_ready, 1);
        chk({tag, "_c_rdata"}, c_rdata, 0);
        chk({tag, "_h_rdata"}, h_rdata, 0);
        chk({tag, "_h_ack"}, h_ack, 0);
        chk({tag, "_mem_cs"}, mem_cs, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_arb_err"}, arb_err, 0);
    endtask

    // Monitor: every RAM access and completion must match the head of its queue.
    logic prev_c_ready = 1'b1;
    always @(negedge Clk) begin
        mem_e_t m;
        cpl_e_t e;
        if (mem_cs) begin
            if (mem_q.size() == 0) chk("mem_unexpected", {24'd0, 8'(mem_addr)}, 32'hFFFF_FFFF);
            else begin
                m = mem_q.pop_front();
                chk("mem_cyc", cyc, m.cyc);
                chk("mem_we", mem_we, m.we);
                chk("mem_addr", mem_addr, m.addr);
                if (m.we) chk("mem_wdata", mem_wdata, m.dat);
            end
        end
        if (h_ack) begin
            if (h_q.size() == 0) chk("h_ack_unexpected", cyc, 32'hFFFF_FFFF);
            else begin
                e = h_q.pop_front();
                chk("h_ack_cyc", cyc, e.cyc);
                chk("h_rdata", h_rdata, e.dat);
            end
        end
        if (c_ready && !prev_c_ready) begin
            if (c_q.size() == 0) chk("c_ready_unexpected", cyc, 32'hFFFF_FFFF);
            else begin
                e = c_q.pop_front();
                chk("c_ready_cyc", cyc, e.cyc);
                chk("c_rdata", c_rdata, e.dat);
            end
        end
        prev_c_ready <= c_ready;
    end

    initial begin
        Reset_n = 1'b0;
        c_rd = 0; c_wr = 0; c_addr = 0; c_wdata = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        repeat (3) step();
        @(negedge Clk);
        check_rst("rst");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        step();

        // Core write then read of 0x0123.
        T = cyc;
        push_mem(T + 2, 1, 'h123, 'hA5); push_c(T + 3, exp_c);
        core_strobe(0, 1, 16'h0123, 8'hA5);
        wait_to(T + 3);
        T = cyc;
        push_mem(T + 2, 0, 'h123, 0); exp_c = 'hA5; push_c(T + 3 + LAT, exp_c);
        core_strobe(1, 0, 16'h0123, 8'h00);
        wait_to(T + 4 + LAT);

        // Host write 0x5A to 0x3FF, then read it back.
        T = cyc;
        push_mem(T + 1, 1, 'h3FF, 'h5A); push_h(T + 2, exp_h);
        host_op(1, 10'h3FF, 8'h5A);
        T = cyc;
        push_mem(T + 1, 0, 'h3FF, 0); exp_h = 'h5A; push_h(T + 2 + LAT, exp_h);
        host_op(0, 10'h3FF, 8'h00);
        repeat (3) step();

        // Simultaneous core strobe and host request: core first.
        T = cyc;
        push_mem(T + 2, 1, 'h010, 'h11); push_c(T + 3, exp_c);
        push_mem(T + 4, 1, 'h020, 'h22); push_h(T + 5, exp_h);
        fork
            core_strobe(0, 1, 16'h0010, 8'h11);
            host_op(1, 10'h020, 8'h22);
        join
        repeat (3) step();

        // Host starvation: counter saturates and host wins over a pending core access.
        T = cyc;
        push_mem(T + 2, 1, 'h040, 'h41); push_c(T + 3, exp_c);
        push_mem(T + 5, 1, 'h050, 'h50); push_h(T + 6, exp_h);
        push_mem(T + 7, 1, 'h041, 'h42); push_c(T + 8, exp_c);
        push_mem(T + 10, 1, 'h042, 'h43); push_c(T + 11, exp_c);
        fork
            host_op(1, 10'h050, 8'h50);
            begin
                core_strobe(0, 1, 16'h0040, 8'h41);
                wait_to(T + 3);
                core_strobe(0, 1, 16'h0041, 8'h42);
                wait_to(T + 8);
                core_strobe(0, 1, 16'h0042, 8'h43);
            end
        join
        wait_to(T + 14);

        // Protocol violations.
        chk("err_clear", arb_err, 0);
        core_strobe(1, 1, 16'h0060, 8'h66);
        chk("err_both", arb_err, 1);
        chk("err_both_ready", c_ready, 1);
        repeat (3) step();
        T = cyc;
        push_mem(T + 2, 1, 'h030, 'h33); push_c(T + 3, exp_c);
        core_strobe(0, 1, 16'h0030, 8'h33);
        core_strobe(1, 0, 16'h0123, 8'h00);
        wait_to(T + 6);
        chk("err_sticky", arb_err, 1);

        // Reset while a host read sits in WAIT.
        T = cyc;
        push_mem(T + 1, 0, 'h3FF, 0);
        h_req = 1'b1; h_we = 1'b0; h_addr = 10'h3FF;
        step();
        step();
        Reset_n = 1'b0;
        h_req = 1'b0;
        @(negedge Clk);
        check_rst("rst_wait");
        exp_c = 0; exp_h = 0;
        @(posedge Clk); #1;
        step();
        Reset_n = 1'b1;
        repeat (8) step();

        // Normal operation afterwards; address bits above AW wrap.
        T = cyc;
        push_mem(T + 2, 0, 'h123, 0); exp_c = 'hA5; push_c(T + 3 + LAT, exp_c);
        core_strobe(1, 0, 16'hFD23, 8'h00);
        wait_to(T + 4 + LAT);
        T = cyc;
        push_mem(T + 1, 0, 'h010, 0); exp_h = 'h11; push_h(T + 2 + LAT, exp_h);
        host_op(0, 10'h010, 8'h00);
        repeat (4) step();

        chk("mem_q_empty", mem_q.size(), 0);
        chk("c_q_empty", c_q.size(), 0);
        chk("h_q_empty", h_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mf8_ram_arb.md
# mf8_ram_arb

Two-port arbiter/sequencer sharing one synchronous single-port byte RAM between the mf8 core data port (LD/ST via ram_read/ram_write/ram_ready) and a host port (loader/debug/RV bus bridge). Captures single-cycle core strobes, sequences RAM access with configurable read latency, and returns a level ready to the core and a one-cycle acknowledge to the host. Core has priority; a wait counter bounds host starvation.

## Interface
- AW, 10: RAM byte-address width; upper address bits ignored (wrap).
- RAM_LAT, 1: RAM read latency in cycles (1..3); data valid RAM_LAT cycles after mem_cs.
- HOST_MAX, 8: host pending cycles without grant before host wins next arbitration (2..255).

- Clk  in  1  clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- c_rd  in  1  core read strobe, single-cycle pulse.
- c_wr  in  1  core write strobe, single-cycle pulse.
- c_addr  in  16  core byte address (Z pointer), sampled with strobe.
- c_wdata  in  8  core write data, sampled with strobe.
- c_rdata  out  8  core read data, registered, held until next core read completes.
- c_ready  out  1  core ready level; 0 while core access pending/active.
- h_req  in  1  host request level; h_we/h_addr/h_wdata stable until h_ack.
- h_we  in  1  host write (1) / read (0).
- h_addr  in  AW  host byte address.
- h_wdata  in  8  host write data.
- h_rdata  out  8  host read data, registered, valid with h_ack and held.
- h_ack  out  1  one-cycle completion pulse.
- mem_cs  out  1  RAM select, one cycle per access.
- mem_we  out  1  RAM write enable, only with mem_cs.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data.
- arb_err  out  1  sticky protocol-violation flag.

## Operation
- Reset values: c_ready=1, c_rdata=0, h_rdata=0, h_ack=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, arb_err=0, state IDLE, core pending=0, wait counter=0.
- Core strobe: c_rd or c_wr latches {we, addr[AW-1:0], wdata} into core-pending register and clears c_ready at that edge.
- States: IDLE, C_ACC, H_ACC, WAIT.
  - IDLE: if core pending and not host-forced -> C_ACC; else if h_req and h_ack=0 -> H_ACC; else stay. Core strobe arriving in IDLE is considered in the following cycle (pending register).
  - C_ACC/H_ACC: mem_cs=1 one cycle (mem_we per op). Write -> IDLE and completion next edge. Read -> WAIT.
  - WAIT: counts RAM_LAT-1 further cycles, captures mem_rdata into c_rdata/h_rdata at the cycle data is valid, -> IDLE.
- Completion: core -> c_ready=1, pending cleared; host -> h_ack=1 for one cycle. Arbiter ignores h_req in the cycle h_ack=1.
- Starvation: wait counter increments each cycle h_req=1 and host not granted; reset on host grant or h_req=0. At HOST_MAX (saturates), host wins the next IDLE decision over a pending core request.
- Violations (set arb_err, strobe dropped): c_rd&c_wr same cycle; core strobe while c_ready=0.
- Write-only ops never change c_rdata/h_rdata.

## Timing
- Core strobe in cycle T, arbiter idle: c_ready=0 from T+1; mem_cs in T+2; write: c_ready=1 at T+3; read: c_rdata valid and c_ready=1 at T+3+RAM_LAT.
- Host h_req rising in T, idle: mem_cs in T+1; write h_ack in T+2; read h_ack with h_rdata in T+2+RAM_LAT.
- Back-to-back: minimum one IDLE cycle between accesses; max throughput one access per 2 cycles (writes).
- Core strobe during host access: c_ready drops at next edge; core access starts after host completion+1 IDLE cycle.
- Reset mid-access: all outputs to reset values immediately; in-flight access abandoned, no h_ack, c_ready=1.

## Test plan
- Core write 0xA5 to 0x0123 then read, RAM_LAT=1: mem_cs/mem_we at T+2 addr 0x123; read c_ready rises T+4 with c_rdata=0xA5.
- Host read of 0x3FF (preloaded 0x5A), RAM_LAT=2: h_ack single pulse at T+4, h_rdata=0x5A, no re-grant during ack cycle.
- Simultaneous core strobe and host h_req rising, counter=0: core served first, host mem_cs exactly 2 cycles after core write's mem_cs.
- Core strobes every 3 cycles with host h_req held, HOST_MAX=4: host granted once counter saturates at 4; c_ready held 0 for delayed core access; no strobes lost.
- c_rd&c_wr together, and strobe while c_ready=0: arb_err=1 sticky, no mem_cs issued for dropped strobe.
- Reset_n low during WAIT: mem_cs=0, h_ack never pulses, c_ready=1, state IDLE; subsequent access completes normally.
